// File: rtl/vga_pkg.sv
// Shared constants, capture-state encoding and colour packing for the VGA
// frame-capture block.
//   VGA_WIDTH/VGA_HEIGHT : default input raster
//   SRC_WIDTH/SRC_HEIGHT : default decimated raster held in the buffer
//   pack_rgb             : 30-bit {R10,G10,B10} -> 12-bit {R4,G4,B4}
package vga_pkg;
    localparam int VGA_WIDTH     = 640;
    localparam int VGA_HEIGHT    = 480;
    localparam int SRC_WIDTH     = 160;
    localparam int SRC_HEIGHT    = 120;
    localparam int NumPixels     = VGA_WIDTH * VGA_HEIGHT;
    localparam int NumColourBits = 12;
    localparam int PixelBits     = 30;
    localparam int AddrBits      = 15;

    typedef enum logic [1:0] {IDLE = 2'd0, SEEK = 2'd1, CAPTURE = 2'd2} cap_state_e;

    // Keep the top nibble of each 10-bit channel.
    function automatic logic [NumColourBits-1:0] pack_rgb(input logic [PixelBits-1:0] px);
        return {4'(px[29:20] >> 6), 4'(px[19:10] >> 6), 4'(px[9:0] >> 6)};
    endfunction
endpackage

// File: rtl/vga_frame_capture_if.sv
// Avalon-ST video beat interface.
//   data          : pixel {R[29:20], G[19:10], B[9:0]}
//   startofpacket : first pixel of a frame
//   endofpacket   : last pixel of a frame
//   valid/ready   : beat handshake, transfer when both high
interface vga_frame_capture_if;
    import vga_pkg::*;

    logic [PixelBits-1:0] data;
    logic                 startofpacket;
    logic                 endofpacket;
    logic                 valid;
    logic                 ready;

    modport master (output data, startofpacket, endofpacket, valid, input ready);
    modport slave  (input data, startofpacket, endofpacket, valid, output ready);
endinterface

// File: rtl/vga_frame_ram.sv
// Simple dual-port frame buffer: one write port, one registered read port.
//   we/wr_addr/wr_data : write port
//   rd_addr/rd_data    : read port, data one cycle after address; a read
//                        colliding with a write returns the old contents
// Storage itself is never reset; only the read register is.
module vga_frame_ram #(
    parameter int DEPTH  = vga_pkg::SRC_WIDTH * vga_pkg::SRC_HEIGHT,
    parameter int ADDR_W = vga_pkg::AddrBits,
    parameter int DATA_W = vga_pkg::NumColourBits
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);
    import vga_pkg::*;

    localparam int IDX_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[wr_addr[IDX_W-1:0]] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) rd_data <= '0;
        else          rd_data <= mem[rd_addr[IDX_W-1:0]];
    end
endmodule

// File: rtl/vga_frame_capture.sv
// Avalon-ST video sink that captures one frame on request, decimated by
// 2**SCALE_SHIFT per axis to 12-bit colour, and checks packet framing.
//   clk, reset_n        : clock, synchronous active-low reset
//   st                  : video input (slave side, ready registered)
//   pause               : forces ready low from the next cycle
//   capture_req         : arms one capture when idle
//   capture_busy        : seeking a frame start or capturing
//   frame_done          : pulse, a good frame is in the buffer
//   frame_error         : pulse per framing error
//   error_count         : saturating framing-error count
//   rd_addr/rd_data     : buffer read port, latency 1
module vga_frame_capture #(
    parameter int VGA_WIDTH   = vga_pkg::VGA_WIDTH,
    parameter int VGA_HEIGHT  = vga_pkg::VGA_HEIGHT,
    parameter int SCALE_SHIFT = 2,
    parameter int ERR_CNT_W   = 8
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    vga_frame_capture_if.slave                    st,
    input  logic                                  pause,
    input  logic                                  capture_req,
    output logic                                  capture_busy,
    output logic                                  frame_done,
    output logic                                  frame_error,
    output logic [ERR_CNT_W-1:0]                  error_count,
    input  logic [vga_pkg::AddrBits-1:0]          rd_addr,
    output logic [vga_pkg::NumColourBits-1:0]     rd_data
);
    import vga_pkg::*;

    localparam int SRC_W = VGA_WIDTH >> SCALE_SHIFT;
    localparam int SRC_H = VGA_HEIGHT >> SCALE_SHIFT;
    localparam int XW    = $clog2(VGA_WIDTH);
    localparam int YW    = $clog2(VGA_HEIGHT);
    localparam logic [XW-1:0] X_LAST = XW'(VGA_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(VGA_HEIGHT - 1);

    localparam logic [1:0] ST_IDLE    = 2'(IDLE);
    localparam logic [1:0] ST_SEEK    = 2'(SEEK);
    localparam logic [1:0] ST_CAPTURE = 2'(CAPTURE);

    logic [1:0]    state;
    logic [XW-1:0] x, x_cur;
    logic [YW-1:0] y, y_cur;
    logic          accept, first_px, in_frame, last_px;
    logic          restart, eop_err, good_end, err_now;
    logic          we;
    logic [AddrBits-1:0]      wr_addr;
    logic [NumColourBits-1:0] wr_data;

    assign capture_busy = (state != ST_IDLE);

    always_comb begin
        accept   = st.valid && st.ready;
        // A start-of-packet beat is pixel 0 whether it opens the frame (SEEK)
        // or interrupts one (CAPTURE); everything below uses x_cur/y_cur.
        first_px = accept && st.startofpacket && (state != ST_IDLE);
        in_frame = first_px || (accept && state == ST_CAPTURE);
        x_cur    = first_px ? '0 : x;
        y_cur    = first_px ? '0 : y;
        last_px  = (x_cur == X_LAST) && (y_cur == Y_LAST);

        // SOP inside a capture outranks any EOP on the same beat.
        restart  = first_px && (state == ST_CAPTURE);
        eop_err  = in_frame && !restart && (st.endofpacket != last_px);
        good_end = in_frame && !restart && st.endofpacket && last_px;
        err_now  = restart || eop_err;

        we       = in_frame && (x_cur[SCALE_SHIFT-1:0] == '0) && (y_cur[SCALE_SHIFT-1:0] == '0);
        wr_addr  = AddrBits'((32'(y_cur >> SCALE_SHIFT) * SRC_W) + 32'(x_cur >> SCALE_SHIFT));
        wr_data  = pack_rgb(st.data);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            st.ready    <= 1'b0;
            frame_done  <= 1'b0;
            frame_error <= 1'b0;
            error_count <= '0;
            x           <= '0;
            y           <= '0;
        end else begin
            st.ready    <= !pause;
            frame_done  <= good_end;
            frame_error <= err_now;
            if (err_now && error_count != {ERR_CNT_W{1'b1}})
                error_count <= error_count + 1'b1;

            if (state == ST_IDLE) begin
                if (capture_req) state <= ST_SEEK;
            end else if (good_end) begin
                state <= ST_IDLE;
            end else if (eop_err) begin
                state <= ST_SEEK;
            end else if (in_frame) begin
                state <= ST_CAPTURE;
            end

            // Raster counters; the frame-final pixel always ends the capture,
            // so y never needs to wrap here.
            if (good_end || eop_err) begin
                x <= '0;
                y <= '0;
            end else if (in_frame) begin
                if (x_cur == X_LAST) begin
                    x <= '0;
                    y <= y_cur + 1'b1;
                end else begin
                    x <= x_cur + 1'b1;
                    y <= y_cur;
                end
            end
        end
    end

    vga_frame_ram #(
        .DEPTH (SRC_W * SRC_H),
        .ADDR_W(AddrBits),
        .DATA_W(NumColourBits)
    ) u_ram (
        .clk    (clk),
        .reset_n(reset_n),
        .we     (we),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .rd_addr(rd_addr),
        .rd_data(rd_data)
    );
endmodule
